// File: rtl/alu_pkg.sv
// Shared ALU arithmetic definitions: operation encoding carried on the sub select.
package alu_pkg;

  typedef enum logic {
    ARITH_ADD = 1'b0,
    ARITH_SUB = 1'b1
  } alu_arith_op_e;

endpackage : alu_pkg

// File: rtl/full_adder_cell.sv
// One-bit full adder; the ripple element of the add datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder_cell

// File: rtl/add.sv
// Ripple-carry adder/subtractor with a one-cycle registered result and overflow flag.
module add
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  alu_arith_op_e    op;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;

  logic             out_valid_q;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  assign op   = alu_arith_op_e'(sub);
  assign bx   = (op == ARITH_SUB) ? ~b : b;
  assign c[0] = cin ^ (op == ARITH_SUB);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (bx[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  // For WIDTH=1, c[WIDTH-1] is c[0], the effective carry-in.
  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (in_valid) begin
      s_d    = sum;
      cout_d = c[WIDTH];
      ovf_d  = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule : add

// File: tb/tb_add.sv
// Directed self-checking bench for add at WIDTH=1 and WIDTH=8.
module tb_add;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       cin;
  logic       sub;
  logic       a1, b1;
  logic [7:0] a8, b8;

  logic       ov1, s1, c1, o1;
  logic       ov8, c8, o8;
  logic [7:0] s8;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  add #(.WIDTH(1)) u_add1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1), .cin(cin), .sub(sub),
    .out_valid(ov1), .s(s1), .cout(c1), .ovf(o1)
  );

  add #(.WIDTH(8)) u_add8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8), .cin(cin), .sub(sub),
    .out_valid(ov8), .s(s8), .cout(c8), .ovf(o8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one WIDTH=1 op and check {cout,s} on the following edge.
  task automatic op1(input string tag, input logic sv, input logic av, input logic bv,
                     input logic cv, input logic [1:0] exp);
    in_valid = 1'b1; sub = sv; a1 = av; b1 = bv; cin = cv;
    @(posedge clk); #1;
    check({tag, "_vld"}, 64'(ov1), 64'd1);
    check(tag, 64'({c1, s1}), 64'(exp));
  endtask

  task automatic op8(input string tag, input logic sv, input logic [7:0] av, input logic [7:0] bv,
                     input logic cv, input logic [7:0] es, input logic ec, input logic eo);
    in_valid = 1'b1; sub = sv; a8 = av; b8 = bv; cin = cv;
    @(posedge clk); #1;
    check({tag, "_vld"}, 64'(ov8), 64'd1);
    check({tag, "_s"},   64'(s8),  64'(es));
    check({tag, "_c"},   64'(c8),  64'(ec));
    check({tag, "_o"},   64'(o8),  64'(eo));
  endtask

  // Hand-computed {cout,s}, indexed by {a,b,cin}.
  logic [1:0] add1_exp [8];
  logic [1:0] sub1_exp [8];

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    add1_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    sub1_exp = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b01};

    rst_n = 1'b0; in_valid = 1'b0; cin = 1'b0; sub = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0;
    #3;
    check("rst_vld8", 64'(ov8), 64'd0);
    check("rst_s8",   64'(s8),  64'd0);
    check("rst_c8",   64'(c8),  64'd0);
    check("rst_o8",   64'(o8),  64'd0);
    check("rst_vld1", 64'(ov1), 64'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1($sformatf("w1add_%0d%0d%0d", v[2], v[1], v[0]), 1'b0, v[2], v[1], v[0], add1_exp[i]);
    end
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1($sformatf("w1sub_%0d%0d%0d", v[2], v[1], v[0]), 1'b1, v[2], v[1], v[0], sub1_exp[i]);
    end

    op8("add_ff01",  1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add_7f01",  1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("add_cin",   1'b0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);
    op8("sub_0503",  1'b1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b1, 1'b0);
    op8("sub_0305",  1'b1, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0);
    op8("sub_8001",  1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    op8("sub_bin",   1'b1, 8'h10, 8'h05, 1'b1, 8'h0A, 1'b1, 1'b0);

    // Back-to-back stream, then idle with changed operands: results must hold.
    op8("b2b_0", 1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    op8("b2b_1", 1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op8("b2b_2", 1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0);
    op8("b2b_3", 1'b0, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);
    in_valid = 1'b0; a8 = 8'h5A; b8 = 8'hC3; cin = 1'b1; sub = 1'b1;
    @(posedge clk); #1;
    check("idle_vld", 64'(ov8), 64'd0);
    check("idle_s",   64'(s8),  64'h80);
    check("idle_c",   64'(c8),  64'd0);
    check("idle_o",   64'(o8),  64'd1);
    @(posedge clk); #1;
    check("hold_s",   64'(s8),  64'h80);
    check("hold_o",   64'(o8),  64'd1);

    // Asynchronous clear between edges; an op offered during reset is dropped.
    rst_n = 1'b0;
    #2;
    check("arst_s", 64'(s8), 64'd0);
    check("arst_o", 64'(o8), 64'd0);
    check("arst_c", 64'(c8), 64'd0);
    in_valid = 1'b1; sub = 1'b0; a8 = 8'h11; b8 = 8'h22; cin = 1'b0;
    @(posedge clk); #1;
    check("rst_drop_vld", 64'(ov8), 64'd0);
    check("rst_drop_s",   64'(s8),  64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_vld", 64'(ov8), 64'd0);
    op8("post_rst_op", 1'b0, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_op_vld", 64'(ov8), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_add
